// File: rtl/sprite_scanline_scanner_pkg.sv
// Shared definitions for the scanline sprite scanner: SAT field helpers,
// scanner state encoding and the per-slot record.
package sprite_scanline_scanner_pkg;

    localparam int SAT_W = 16;
    localparam int SPR_H = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic       valid;
        logic [7:0] x;
        logic [3:0] yofs;
    } slot_t;

    function automatic logic [7:0] sat_y(input logic [SAT_W-1:0] entry);
        return entry[15:8];
    endfunction

    function automatic logic [7:0] sat_x(input logic [SAT_W-1:0] entry);
        return entry[7:0];
    endfunction

    // Returns {hit, row}. The 9-bit wrap makes sprites below the target line
    // produce a large distance, so one unsigned compare covers both sides.
    function automatic logic [4:0] row_hit(input logic [8:0] tl, input logic [7:0] y);
        logic [8:0] d;
        d = tl - {1'b0, y};
        return {(d < 9'(SPR_H)), d[3:0]};
    endfunction

endpackage

// File: rtl/sprite_scanline_scanner_slot.sv
// One renderer slot: shadow record filled during the scan, active record
// copied at the line commit, and the registered hstart compare.
module sprite_slot_reg
    import sprite_scanline_scanner_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       shadow_clr_i,
    input  logic       shadow_ld_i,
    input  logic [7:0] x_i,
    input  logic [3:0] yofs_i,
    input  logic       commit_i,
    input  logic       commit_clr_i,
    input  logic [8:0] hpos_i,
    output logic       hstart_o,
    output logic [3:0] yofs_o,
    output logic       valid_o
);

    slot_t sh_q, sh_d;
    slot_t act_q, act_d;
    logic  hstart_q, hstart_d;

    always_comb begin
        sh_d     = sh_q;
        act_d    = act_q;
        hstart_d = act_q.valid && (hpos_i == {1'b0, act_q.x});
        if (shadow_clr_i) begin
            sh_d = '0;
        end else if (shadow_ld_i) begin
            sh_d.valid = 1'b1;
            sh_d.x     = x_i;
            sh_d.yofs  = yofs_i;
        end
        if (commit_i) begin
            act_d = sh_q;
        end else if (commit_clr_i) begin
            act_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            sh_q     <= '0;
            act_q    <= '0;
            hstart_q <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            act_q    <= act_d;
            hstart_q <= hstart_d;
        end
    end

    assign hstart_o = hstart_q;
    assign yofs_o   = act_q.yofs;
    assign valid_o  = act_q.valid;

endmodule

// File: rtl/sprite_scanline_scanner.sv
// Per-scanline sprite selector: scans the SAT during hsync for the next line
// into shadow slots, then commits them to the active slots at hpos == 0.
module sprite_scanline_scanner
    import sprite_scanline_scanner_pkg::*;
#(
    parameter int NUM_SPRITES = 16,
    parameter int SLOTS       = 4,
    parameter int AW          = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [8:0]           hpos_i,
    input  logic [8:0]           vpos_i,
    input  logic                 hsync_i,
    output logic [AW-1:0]        sat_addr_o,
    input  logic [SAT_W-1:0]     sat_data_i,
    output logic [SLOTS-1:0]     slot_hstart_o,
    output logic [4*SLOTS-1:0]   slot_yofs_o,
    output logic [SLOTS-1:0]     slot_valid_o,
    output logic                 overflow_o,
    output logic                 busy_o,
    output logic [1:0]           state_o
);

    localparam int CW = $clog2(SLOTS + 1);

    scan_state_e state_q, state_d;

    logic          hsync_q;
    logic          start;
    logic          commit;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_vld_q, rd_vld_d;
    logic [8:0]    tl_q, tl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sh_ovf_q, sh_ovf_d;
    logic          ovf_q, ovf_d;

    logic          launch;
    logic          issuing;
    logic          commit_copy;
    logic          commit_clr;
    logic [4:0]    hit_info;
    logic          hit;
    logic          full;
    logic          alloc;
    logic [SLOTS-1:0] ld_vec;
    logic [7:0]    entry_x;

    assign start  = hsync_i & ~hsync_q;
    assign commit = (hpos_i == 9'd0);

    // State register
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start coinciding with the commit relaunches from DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_SCAN;
            ST_SCAN: if (addr_q == AW'(NUM_SPRITES - 1)) state_d = ST_DONE;
            ST_DONE: if (commit) state_d = start ? ST_SCAN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        launch      = start && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && commit));
        issuing     = (state_q == ST_SCAN);
        commit_copy = commit && (state_q == ST_DONE);
        commit_clr  = commit && (state_q != ST_DONE);
        busy_o      = (state_q == ST_SCAN);
        state_o     = state_q;
    end

    assign hit_info = row_hit(tl_q, sat_y(sat_data_i));
    assign entry_x  = sat_x(sat_data_i);
    assign hit      = rd_vld_q && hit_info[4];
    assign full     = (cnt_q >= CW'(SLOTS));
    assign alloc    = hit && !full;

    // Slots fill in SAT order: the hit count is the index of the next free slot
    always_comb begin
        ld_vec = '0;
        for (int k = 0; k < SLOTS; k++) begin
            ld_vec[k] = alloc && (cnt_q == CW'(k));
        end
    end

    always_comb begin
        addr_d   = issuing ? addr_q + AW'(1) : '0;
        rd_vld_d = issuing;
        tl_d     = launch ? vpos_i + 9'd1 : tl_q;
        cnt_d    = cnt_q;
        sh_ovf_d = sh_ovf_q;
        ovf_d    = ovf_q;
        if (launch) begin
            cnt_d    = '0;
            sh_ovf_d = 1'b0;
        end else if (alloc) begin
            cnt_d = cnt_q + CW'(1);
        end else if (hit) begin
            sh_ovf_d = 1'b1;
        end
        if (commit_copy) begin
            ovf_d = sh_ovf_q;
        end else if (commit_clr) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            hsync_q  <= 1'b0;
            addr_q   <= '0;
            rd_vld_q <= 1'b0;
            tl_q     <= '0;
            cnt_q    <= '0;
            sh_ovf_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            hsync_q  <= hsync_i;
            addr_q   <= addr_d;
            rd_vld_q <= rd_vld_d;
            tl_q     <= tl_d;
            cnt_q    <= cnt_d;
            sh_ovf_q <= sh_ovf_d;
            ovf_q    <= ovf_d;
        end
    end

    assign sat_addr_o = addr_q;
    assign overflow_o = ovf_q;

    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        sprite_slot_reg u_slot (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .shadow_clr_i (launch),
            .shadow_ld_i  (ld_vec[k]),
            .x_i          (entry_x),
            .yofs_i       (hit_info[3:0]),
            .commit_i     (commit_copy),
            .commit_clr_i (commit_clr),
            .hpos_i       (hpos_i),
            .hstart_o     (slot_hstart_o[k]),
            .yofs_o       (slot_yofs_o[4*k +: 4]),
            .valid_o      (slot_valid_o[k])
        );
    end

endmodule

// File: tb/tb_sprite_scanline_scanner.sv
// Bench for sprite_scanline_scanner: a video-timing driver, a SAT memory
// model, and a per-line scoreboard fed by a reference selection model.
module tb_sprite_scanline_scanner;

    localparam int N       = 16;
    localparam int SLOTS   = 4;
    localparam int H_TOTAL = 300;
    localparam int HS_BEG  = 260;
    localparam int HS_END  = 276;
    localparam int W       = 62;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [8:0]  hpos_i;
    logic [8:0]  vpos_i;
    logic        hsync_i;
    logic [3:0]  sat_addr_o;
    logic [15:0] sat_data_i;
    logic [3:0]  slot_hstart_o;
    logic [15:0] slot_yofs_o;
    logic [3:0]  slot_valid_o;
    logic        overflow_o;
    logic        busy_o;
    logic [1:0]  state_o;

    logic [15:0] sat_mem [N];
    logic [3:0]  sat_addr_q;

    // Entry layout: {line[61:53], ovf[52], valid[51:48], yofs[47:32], x[31:0]}
    logic [W-1:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sprite_scanline_scanner #(.NUM_SPRITES(N), .SLOTS(SLOTS), .AW(4)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .hpos_i        (hpos_i),
        .vpos_i        (vpos_i),
        .hsync_i       (hsync_i),
        .sat_addr_o    (sat_addr_o),
        .sat_data_i    (sat_data_i),
        .slot_hstart_o (slot_hstart_o),
        .slot_yofs_o   (slot_yofs_o),
        .slot_valid_o  (slot_valid_o),
        .overflow_o    (overflow_o),
        .busy_o        (busy_o),
        .state_o       (state_o)
    );

    // SAT RAM with one cycle of read latency
    always @(posedge clk) sat_addr_q <= sat_addr_o;
    assign sat_data_i = sat_mem[sat_addr_q];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: sprites whose 16-row band contains the target line, first SLOTS in SAT order
    function automatic logic [W-1:0] model_line(input logic [8:0] tl);
        logic [3:0]  v;
        logic [15:0] yo;
        logic [31:0] xs;
        logic        ovf;
        int          n;
        int          d;
        v = '0; yo = '0; xs = '0; ovf = 1'b0; n = 0;
        for (int i = 0; i < N; i++) begin
            d = (int'(tl) - int'(sat_mem[i][15:8]) + 512) % 512;
            if (d < 16) begin
                if (n < SLOTS) begin
                    v[n]          = 1'b1;
                    yo[4*n +: 4]  = 4'(d);
                    xs[8*n +: 8]  = sat_mem[i][7:0];
                    n++;
                end else begin
                    ovf = 1'b1;
                end
            end
        end
        return {tl, ovf, v, yo, xs};
    endfunction

    task automatic drive_line(input logic [8:0] v, input logic hs_en, input logic rst_en);
        for (int h = 0; h < H_TOTAL; h++) begin
            @(posedge clk);
            #1;
            if (rst_en && h == 265) check("scan_busy", 64'(busy_o), 64'd1);
            if (rst_en && h == 266) begin
                check("abort_busy",   64'(busy_o), 64'd0);
                check("abort_valid",  64'(slot_valid_o), 64'd0);
                check("abort_ovf",    64'(overflow_o), 64'd0);
                check("abort_hstart", 64'(slot_hstart_o), 64'd0);
                check("abort_yofs",   64'(slot_yofs_o), 64'd0);
                check("abort_addr",   64'(sat_addr_o), 64'd0);
                check("abort_state",  64'(state_o), 64'd0);
            end
            hpos_i  = 9'(h);
            vpos_i  = v;
            hsync_i = hs_en && (h >= HS_BEG) && (h < HS_END);
            if (rst_en && h == 265) reset_i = 1'b0;
            if (rst_en && h == 280) reset_i = 1'b1;
        end
    endtask

    // kind: 0 = normal scan, 1 = hsync withheld, 2 = reset during the scan
    task automatic run_job(input logic [8:0] t, input int kind);
        logic [8:0] vp;
        vp = t - 9'd1;
        if (kind == 0) exp_q.push_back(model_line(t));
        else           exp_q.push_back({t, 1'b1, 52'd0});
        drive_line(vp, kind != 1, kind == 2);
        drive_line(t, 1'b1, 1'b0);
    endtask

    task automatic fill_sat(input logic [7:0] y);
        for (int i = 0; i < N; i++) sat_mem[i] = {y, 8'(10 + i)};
    endtask

    // Monitor: records each line's slot state and hstart pulses, then scores it
    initial begin
        int          pcnt [SLOTS];
        logic [8:0]  ppos [SLOTS];
        logic [3:0]  s_valid;
        logic [15:0] s_yofs;
        logic        s_ovf;
        logic [W-1:0] e;
        s_valid = '0; s_yofs = '0; s_ovf = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin pcnt[k] = 0; ppos[k] = '1; end
        forever begin
            @(negedge clk);
            if (hpos_i == 9'd0) begin
                for (int k = 0; k < SLOTS; k++) begin pcnt[k] = 0; ppos[k] = '1; end
            end
            for (int k = 0; k < SLOTS; k++) begin
                if (slot_hstart_o[k]) begin pcnt[k]++; ppos[k] = hpos_i; end
            end
            if (hpos_i == 9'd2) begin
                s_valid = slot_valid_o;
                s_yofs  = slot_yofs_o;
                s_ovf   = overflow_o;
            end
            if (hpos_i == 9'(H_TOTAL - 1) && exp_q.size() > 0 && exp_q[0][61:53] == vpos_i) begin
                e = exp_q.pop_front();
                check("line_valid", 64'(s_valid), 64'(e[51:48]));
                check("line_yofs",  64'(s_yofs),  64'(e[47:32]));
                check("line_ovf",   64'(s_ovf),   64'(e[52]));
                for (int k = 0; k < SLOTS; k++) begin
                    check("hstart_cnt", 64'(pcnt[k]), e[48+k] ? 64'd1 : 64'd0);
                    check("hstart_pos", 64'(ppos[k]),
                          e[48+k] ? 64'({1'b0, e[8*k +: 8]} + 9'd1) : 64'h1ff);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] t;
        int         yi;
        int         dens;
        reset_i = 1'b0;
        hpos_i  = '0;
        vpos_i  = '0;
        hsync_i = 1'b0;
        fill_sat(8'd200);
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   64'(busy_o), 64'd0);
        check("reset_valid",  64'(slot_valid_o), 64'd0);
        check("reset_ovf",    64'(overflow_o), 64'd0);
        check("reset_hstart", 64'(slot_hstart_o), 64'd0);
        check("reset_addr",   64'(sat_addr_o), 64'd0);
        check("reset_state",  64'(state_o), 64'd0);
        reset_i = 1'b1;

        // No sprite anywhere near the line
        fill_sat(8'd200);
        run_job(9'd10, 0);
        // Single hit at row 5
        sat_mem[3] = {8'd10, 8'd40};
        run_job(9'd15, 0);
        // Six hits, four slots
        fill_sat(8'd200);
        for (int i = 0; i < 6; i++) sat_mem[i] = {8'd20, 8'(10 + 10 * i)};
        run_job(9'd20, 0);
        // Band edges of a sprite at y=10
        fill_sat(8'd200);
        sat_mem[0] = {8'd10, 8'd77};
        run_job(9'd9, 0);
        run_job(9'd26, 0);
        run_job(9'd10, 0);
        run_job(9'd25, 0);
        // Reset in mid-scan, then a clean rescan
        sat_mem[0] = {8'd30, 8'd50};
        run_job(9'd35, 2);
        run_job(9'd35, 0);
        // Missed scan, then recovery
        run_job(9'd40, 1);
        run_job(9'd41, 0);
        // Target line wraps from vpos 511 to 0
        fill_sat(8'd200);
        sat_mem[5] = {8'd0, 8'd99};
        sat_mem[6] = {8'd250, 8'd7};
        run_job(9'd0, 0);

        for (int j = 0; j < 20; j++) begin
            t    = 9'($urandom_range(1, 300));
            dens = $urandom_range(0, 7);
            for (int i = 0; i < N; i++) begin
                yi = int'(t) - int'($urandom_range(0, 24));
                if (yi < 0 || yi > 255 || $urandom_range(0, 7) >= dens) yi = $urandom_range(0, 255);
                sat_mem[i] = {8'(yi), 8'($urandom_range(1, 240))};
            end
            run_job(t, 0);
        end

        repeat (2) @(posedge clk);
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
